// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the on-chip RAM port arbiter.
// The read tag records which master owns the read that returns next cycle.
package ram_arb_pkg;

  localparam int unsigned NUM_WORDS = 5120;
  localparam int unsigned ERR_W     = 8;

  typedef enum logic {
    PORT_M0 = 1'b0,
    PORT_M1 = 1'b1
  } port_e;

  typedef struct packed {
    logic  valid;
    port_e owner;
    logic  oor;
  } rd_tag_t;

  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered priority
// pointer that flips to the other requester after every grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant
);
  import ram_arb_pkg::*;

  port_e prio_q;
  port_e prio_d;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (prio_q == PORT_M0) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_comb begin
    prio_d = prio_q;
    if (grant[0])      prio_d = PORT_M1;
    else if (grant[1]) prio_d = PORT_M0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prio_q <= PORT_M0;
    else       prio_q <= prio_d;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between two Avalon-MM masters with round-robin
// grant, fixed 1-cycle read latency and out-of-range access trapping.
module ram_port_arbiter #(
  parameter int unsigned ADDR_W    = 13,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BE_W      = 4,
  parameter int unsigned NUM_WORDS = 5120,
  parameter int unsigned ERR_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata,
  output logic [ERR_W-1:0]  err_count
);
  import ram_arb_pkg::*;

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic [1:0]        req;
  logic [1:0]        arb_req;
  logic [1:0]        grant;
  logic              granted;
  port_e             winner;
  logic [ADDR_W-1:0] win_address;
  logic [BE_W-1:0]   win_byteenable;
  logic [DATA_W-1:0] win_writedata;
  logic              win_write;
  logic              in_range;
  rd_tag_t           tag_q;
  logic [ERR_W-1:0]  err_q;

  assign req[0] = m0_read | m0_write;
  assign req[1] = m1_read | m1_write;

  // Requests are masked while reset is held so nothing reaches the RAM.
  assign arb_req = req & {2{~reset}};

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (arb_req),
    .grant (grant)
  );

  assign granted = |grant;
  assign winner  = grant[1] ? PORT_M1 : PORT_M0;

  assign m0_waitrequest = req[0] & ~grant[0];
  assign m1_waitrequest = req[1] & ~grant[1];

  // A simultaneous read+write is treated as a write.
  always_comb begin
    win_address    = m0_address;
    win_byteenable = m0_byteenable;
    win_writedata  = m0_writedata;
    win_write      = m0_write;
    if (winner == PORT_M1) begin
      win_address    = m1_address;
      win_byteenable = m1_byteenable;
      win_writedata  = m1_writedata;
      win_write      = m1_write;
    end
  end

  assign in_range = addr_in_range(32'(win_address), NUM_WORDS);

  always_comb begin
    ram_address    = '0;
    ram_byteenable = '0;
    ram_writedata  = '0;
    ram_chipselect = 1'b0;
    ram_write      = 1'b0;
    if (granted) begin
      ram_address    = win_address;
      ram_byteenable = win_write ? win_byteenable : '1;
      ram_writedata  = win_writedata;
      ram_chipselect = in_range;
      ram_write      = win_write & in_range;
    end
  end

  assign ram_clken = 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q <= '0;
    end else begin
      tag_q.valid <= granted & ~win_write;
      tag_q.owner <= winner;
      tag_q.oor   <= ~in_range;
    end
  end

  always_comb begin
    m0_readdatavalid = tag_q.valid & (tag_q.owner == PORT_M0);
    m1_readdatavalid = tag_q.valid & (tag_q.owner == PORT_M1);
    m0_readdata      = '0;
    m1_readdata      = '0;
    if (m0_readdatavalid && !tag_q.oor) m0_readdata = ram_readdata;
    if (m1_readdatavalid && !tag_q.oor) m1_readdata = ram_readdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= '0;
    end else if (granted && !in_range && err_q != ERR_MAX) begin
      err_q <= err_q + 1'b1;
    end
  end

  assign err_count = err_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 1-cycle RAM model.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [12:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_writedata;
  logic [31:0] ram_readdata = '0;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:5119];

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_W(13), .DATA_W(32), .BE_W(4), .NUM_WORDS(5120), .ERR_W(8)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write), .ram_writedata(ram_writedata),
    .ram_clken(ram_clken), .ram_readdata(ram_readdata), .err_count(err_count)
  );

  always @(posedge clk) begin
    if (ram_clken && ram_chipselect && ram_address < 13'd5120) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) mem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
      end else begin
        ram_readdata <= mem[ram_address];
      end
    end
  end

  typedef struct {
    logic r0, w0; logic [12:0] a0; logic [3:0] be0; logic [31:0] d0;
    logic r1, w1; logic [12:0] a1; logic [3:0] be1; logic [31:0] d1;
    logic wq0, wq1, cs, we; logic [12:0] ra; logic [3:0] rbe;
    logic v0; logic [31:0] rd0; logic v1; logic [31:0] rd1; logic [7:0] err;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
    m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
  endtask

  function automatic logic [31:0] mem_sum();
    logic [31:0] s = '0;
    for (int i = 0; i < 5120; i++) s = s + mem[i];
    return s;
  endfunction

  initial begin
    int          wcount;
    logic [31:0] sum_before;

    for (int i = 0; i < 5120; i++) mem[i] = '0;
    mem[1] = 32'h1111_0001;
    mem[2] = 32'h2222_0002;

    //          r0 w0 a0       be0   d0            r1 w1 a1        be1 d1  wq0 wq1 cs we ra        rbe    v0 rd0           v1 rd1           err
    vecs[0]  = '{0, 1, 13'h010, 4'h3, 32'hA5A51234, 0, 0, 13'h000, 0, 0,  0,  0,  1, 1, 13'h010, 4'h3,  0, 32'h0,        0, 32'h0,        8'd0};
    vecs[1]  = '{1, 0, 13'h010, 4'h0, 32'h0,        0, 0, 13'h000, 0, 0,  0,  0,  1, 0, 13'h010, 4'hF,  0, 32'h0,        0, 32'h0,        8'd0};
    vecs[2]  = '{0, 0, 13'h000, 4'h0, 32'h0,        1, 0, 13'h002, 0, 0,  0,  0,  1, 0, 13'h002, 4'hF,  1, 32'h00001234, 0, 32'h0,        8'd0};
    vecs[3]  = '{1, 0, 13'h001, 4'h0, 32'h0,        1, 0, 13'h002, 0, 0,  0,  1,  1, 0, 13'h001, 4'hF,  0, 32'h0,        1, 32'h22220002, 8'd0};
    vecs[4]  = '{1, 0, 13'h001, 4'h0, 32'h0,        1, 0, 13'h002, 0, 0,  1,  0,  1, 0, 13'h002, 4'hF,  1, 32'h11110001, 0, 32'h0,        8'd0};
    vecs[5]  = '{1, 0, 13'h001, 4'h0, 32'h0,        1, 0, 13'h002, 0, 0,  0,  1,  1, 0, 13'h001, 4'hF,  0, 32'h0,        1, 32'h22220002, 8'd0};
    vecs[6]  = '{1, 0, 13'h001, 4'h0, 32'h0,        1, 0, 13'h002, 0, 0,  1,  0,  1, 0, 13'h002, 4'hF,  1, 32'h11110001, 0, 32'h0,        8'd0};
    vecs[7]  = '{1, 0, 13'h001, 4'h0, 32'h0,        1, 0, 13'h002, 0, 0,  0,  1,  1, 0, 13'h001, 4'hF,  0, 32'h0,        1, 32'h22220002, 8'd0};
    vecs[8]  = '{1, 0, 13'h001, 4'h0, 32'h0,        1, 0, 13'h002, 0, 0,  1,  0,  1, 0, 13'h002, 4'hF,  1, 32'h11110001, 0, 32'h0,        8'd0};
    vecs[9]  = '{1, 0, 13'h001, 4'h0, 32'h0,        1, 0, 13'h002, 0, 0,  0,  1,  1, 0, 13'h001, 4'hF,  0, 32'h0,        1, 32'h22220002, 8'd0};
    vecs[10] = '{0, 0, 13'h000, 4'h0, 32'h0,        1, 0, 13'h002, 0, 0,  0,  0,  1, 0, 13'h002, 4'hF,  1, 32'h11110001, 0, 32'h0,        8'd0};
    vecs[11] = '{1, 1, 13'h020, 4'hF, 32'hDEADBEEF, 0, 0, 13'h000, 0, 0,  0,  0,  1, 1, 13'h020, 4'hF,  0, 32'h0,        1, 32'h22220002, 8'd0};
    vecs[12] = '{1, 0, 13'h020, 4'h0, 32'h0,        0, 0, 13'h000, 0, 0,  0,  0,  1, 0, 13'h020, 4'hF,  0, 32'h0,        0, 32'h0,        8'd0};
    vecs[13] = '{0, 0, 13'h000, 4'h0, 32'h0,        1, 0, 13'h1400, 0, 0, 0,  0,  0, 0, 13'h1400, 4'hF, 1, 32'hDEADBEEF, 0, 32'h0,        8'd0};
    vecs[14] = '{0, 0, 13'h000, 4'h0, 32'h0,        0, 0, 13'h000, 0, 0,  0,  0,  0, 0, 13'h000, 4'hF,  0, 32'h0,        1, 32'h0,        8'd1};

    // Reset held with a pending m0 read.
    idle_inputs();
    reset = 1;
    m0_read = 1; m0_address = 13'h010;
    @(negedge clk);
    check("rst_rdv0", 32'(m0_readdatavalid), 32'd0);
    check("rst_rdv1", 32'(m1_readdatavalid), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_cs", 32'(ram_chipselect), 32'd0);
    check("rst_we", 32'(ram_write), 32'd0);
    check("rst_addr", 32'(ram_address), 32'd0);
    check("rst_rd0", m0_readdata, 32'd0);
    check("rst_clken", 32'(ram_clken), 32'd1);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    check("post_rst_wq0", 32'(m0_waitrequest), 32'd0);
    check("post_rst_cs", 32'(ram_chipselect), 32'd1);
    check("post_rst_addr", 32'(ram_address), 32'h010);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("post_rst_rdv0", 32'(m0_readdatavalid), 32'd1);
    check("post_rst_rd0", m0_readdata, 32'd0);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      m0_read = vecs[i].r0; m0_write = vecs[i].w0; m0_address = vecs[i].a0;
      m0_byteenable = vecs[i].be0; m0_writedata = vecs[i].d0;
      m1_read = vecs[i].r1; m1_write = vecs[i].w1; m1_address = vecs[i].a1;
      m1_byteenable = vecs[i].be1; m1_writedata = vecs[i].d1;
      @(negedge clk);
      check($sformatf("v%0d_wq0", i), 32'(m0_waitrequest), 32'(vecs[i].wq0));
      check($sformatf("v%0d_wq1", i), 32'(m1_waitrequest), 32'(vecs[i].wq1));
      check($sformatf("v%0d_cs", i), 32'(ram_chipselect), 32'(vecs[i].cs));
      check($sformatf("v%0d_we", i), 32'(ram_write), 32'(vecs[i].we));
      check($sformatf("v%0d_addr", i), 32'(ram_address), 32'(vecs[i].ra));
      if (vecs[i].cs) check($sformatf("v%0d_be", i), 32'(ram_byteenable), 32'(vecs[i].rbe));
      check($sformatf("v%0d_rdv0", i), 32'(m0_readdatavalid), 32'(vecs[i].v0));
      check($sformatf("v%0d_rd0", i), m0_readdata, vecs[i].rd0);
      check($sformatf("v%0d_rdv1", i), 32'(m1_readdatavalid), 32'(vecs[i].v1));
      check($sformatf("v%0d_rd1", i), m1_readdata, vecs[i].rd1);
      check($sformatf("v%0d_err", i), 32'(err_count), 32'(vecs[i].err));
      @(posedge clk); #1;
    end

    // 300 out-of-range writes: counter saturates, RAM untouched.
    sum_before = mem_sum();
    wcount = 0;
    m1_write = 1; m1_address = 13'h1FFF; m1_byteenable = 4'hF; m1_writedata = 32'hFFFF_FFFF;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ram_chipselect || ram_write) wcount++;
      if (i == 100) check("oor_err_mid", 32'(err_count), 32'd101);
      @(posedge clk); #1;
    end
    idle_inputs();
    @(negedge clk);
    check("oor_err_sat", 32'(err_count), 32'hFF);
    check("oor_ram_access", 32'(wcount), 32'd0);
    check("oor_mem_sum", mem_sum(), sum_before);
    @(posedge clk); #1;

    // Reset one cycle after an m0 read grant discards the read.
    m0_read = 1; m0_address = 13'h001;
    @(negedge clk);
    check("rr_grant_cs", 32'(ram_chipselect), 32'd1);
    @(posedge clk); #1;
    reset = 1;
    idle_inputs();
    @(negedge clk);
    check("rr_rdv0", 32'(m0_readdatavalid), 32'd0);
    check("rr_rd0", m0_readdata, 32'd0);
    check("rr_err", 32'(err_count), 32'd0);
    @(posedge clk); #1;
    reset = 0;
    m0_read = 1; m0_address = 13'h001;
    m1_read = 1; m1_address = 13'h002;
    @(negedge clk);
    check("rr_rdv0_after", 32'(m0_readdatavalid), 32'd0);
    check("rr_prio_wq0", 32'(m0_waitrequest), 32'd0);
    check("rr_prio_wq1", 32'(m1_waitrequest), 32'd1);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("rr_final_rdv0", 32'(m0_readdatavalid), 32'd1);
    check("rr_final_rd0", m0_readdata, 32'h1111_0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
